sample_divide_seq: RTL and testbench

//  Multi-cycle signed divider for audio sample arithmetic. It is the sequential counterpart to the

---
 rtl/sample_divide_seq_if.sv | 26 ++
 rtl/sample_divide_seq.sv | 137 +++++++++++++
 tb/tb_sample_divide_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_divide_seq_if.sv
// Operand/result handshake bundle for the sequential signed divider.
// master = operand producer and result consumer, slave = divider.
interface sample_divide_seq_if #(
   parameter int BITSA = 16,
   parameter int BITSB = 16
);
   logic                   in_valid;
   logic                   in_ready;
   logic [BITSA-1:0]       a;
   logic [BITSB-1:0]       b;
   logic                   out_valid;
   logic                   out_ready;
   logic [BITSA+BITSB-1:0] q;
   logic [BITSB-1:0]       r;
   logic                   div_zero;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, q, r, div_zero
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, q, r, div_zero
   );
endinterface

// File: rtl/sample_divide_seq.sv
// Radix-2 restoring signed divider, Q/R truncate toward zero; result valid BITSA+1 edges after accept.
// One operation in flight: in_ready only in IDLE, result held in DONE until out_ready.
module sample_divide_seq #(
   parameter int BITSA = 16,
   parameter int BITSB = 16
) (
   input  logic               clk,
   input  logic               rst,
   sample_divide_seq_if.slave bus
);
   localparam int QW = BITSA + BITSB;
   localparam int CW = (BITSA > 1) ? $clog2(BITSA) : 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(BITSA - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIVIDE,
      S_FIXUP,
      S_DONE
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [BITSA-1:0] dq;      // dividend bits shift out the top, quotient bits shift in the bottom
   logic [BITSB-1:0] rem;
   logic [BITSB-1:0] mag_b;
   logic             sign_q;
   logic             sign_r;
   logic             zero;

   logic             in_ready_q;
   logic             out_valid_q;
   logic [QW-1:0]    q_q;
   logic [BITSB-1:0] r_q;
   logic             div_zero_q;

   // Operand magnitudes; the most negative value maps to its unsigned magnitude.
   logic [BITSA-1:0] a_mag;
   logic [BITSB-1:0] b_mag;
   assign a_mag = bus.a[BITSA-1] ? (~bus.a + BITSA'(1)) : bus.a;
   assign b_mag = bus.b[BITSB-1] ? (~bus.b + BITSB'(1)) : bus.b;

   // The stored remainder is always < |B|, so its top bit of the BITSB+1-bit partial remainder
   // is implicitly zero; only the shifted trial value needs the extra bit.
   logic [BITSB:0] rem_shift;
   logic [BITSB:0] rem_sub;
   logic           take;
   assign rem_shift = {rem, dq[BITSA-1]};
   assign rem_sub   = rem_shift - {1'b0, mag_b};
   assign take      = ~rem_sub[BITSB];

   logic [QW-1:0]    q_mag;
   logic [QW-1:0]    q_neg;
   logic [BITSB-1:0] r_neg;
   assign q_mag = {{BITSB{1'b0}}, dq};
   assign q_neg = ~q_mag + QW'(1);
   assign r_neg = ~rem + BITSB'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         dq          <= '0;
         rem         <= '0;
         mag_b       <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         zero        <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         q_q         <= '0;
         r_q         <= '0;
         div_zero_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  dq         <= a_mag;
                  mag_b      <= b_mag;
                  sign_q     <= bus.a[BITSA-1] ^ bus.b[BITSB-1];
                  sign_r     <= bus.a[BITSA-1];
                  zero       <= (bus.b == '0);
                  rem        <= '0;
                  cnt        <= '0;
                  in_ready_q <= 1'b0;
                  state      <= S_DIVIDE;
               end
            end

            S_DIVIDE: begin
               // B==0 still runs every iteration so latency is data independent.
               rem <= take ? rem_sub[BITSB-1:0] : rem_shift[BITSB-1:0];
               dq  <= {dq[BITSA-2:0], take};
               if (cnt == LAST_ITER) begin
                  cnt   <= '0;
                  state <= S_FIXUP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            S_FIXUP: begin
               if (zero) begin
                  q_q <= '0;
                  r_q <= '0;
               end else begin
                  q_q <= sign_q ? q_neg : q_mag;
                  r_q <= sign_r ? r_neg : rem;
               end
               div_zero_q  <= zero;
               out_valid_q <= 1'b1;
               state       <= S_DONE;
            end

            S_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= S_IDLE;
               end
            end

            default: begin
               state       <= S_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.q         = q_q;
   assign bus.r         = r_q;
   assign bus.div_zero  = div_zero_q;
endmodule

// File: tb/tb_sample_divide_seq.sv
// Bench for sample_divide_seq: directed corner cases plus random operands against an arithmetic model.
module tb_sample_divide_seq;
   localparam int BA = 16;
   localparam int BB = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sample_divide_seq_if #(.BITSA(BA), .BITSB(BB)) bus ();
   sample_divide_seq #(.BITSA(BA), .BITSB(BB)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                 output logic [31:0] q, output logic [15:0] r, output logic dz);
      int ai;
      int bi;
      ai = $signed(a);
      bi = $signed(b);
      if (bi == 0) begin
         q = '0; r = '0; dz = 1'b1;
      end else begin
         q = 32'(ai / bi); r = 16'(ai % bi); dz = 1'b0;
      end
   endfunction

   // Runs one operation with out_ready high; captures the result and the state one edge later.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] q, output logic [15:0] r, output logic dz,
                        output int lat, output logic ov_after, output logic ir_after,
                        output int t_acc);
      int n;
      n = 0;
      while (!bus.in_ready && n < 100) begin step(); n++; end
      bus.a = a; bus.b = b; bus.in_valid = 1'b1;
      step();
      t_acc = cyc;
      bus.in_valid = 1'b0;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      lat = 0;
      while (!bus.out_valid && lat < 100) begin step(); lat++; end
      q = bus.q; r = bus.r; dz = bus.div_zero;
      step();
      ov_after = bus.out_valid;
      ir_after = bus.in_ready;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.a = '0; bus.b = '0;
      rst = 1'b1;
      step(); step();
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.q !== 32'h0 ||
          bus.r !== 16'h0 || bus.div_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: got in_ready=%b out_valid=%b q=%h r=%h dz=%b exp 1 0 0 0 0",
                  bus.in_ready, bus.out_valid, bus.q, bus.r, bus.div_zero);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      logic [31:0] q; logic [15:0] r; logic dz, ova, ira; int lat, t;
      do_op(16'd100, 16'd7, q, r, dz, lat, ova, ira, t);
      n_checks++;
      if (q !== 32'd14 || r !== 16'd2 || dz !== 1'b0) begin
         n_fail++; $display("FAIL basic_result: got q=%0d r=%0d dz=%b exp 14 2 0", q, r, dz);
      end
      n_checks++;
      if (lat !== 17) begin n_fail++; $display("FAIL basic_latency: got %0d exp 17", lat); end
      n_checks++;
      if (ova !== 1'b0 || ira !== 1'b1) begin
         n_fail++; $display("FAIL basic_one_cycle: got out_valid=%b in_ready=%b exp 0 1", ova, ira);
      end
   endtask

   task automatic test_signs();
      int ta[7] = '{-100, 100, -100, 6, -32768, 32767, -32768};
      int tb[7] = '{7, -7, -7, 7, -32768, -32768, 7};
      int tq[7] = '{-14, -14, 14, 0, 1, 0, -4681};
      int tr[7] = '{-2, 2, -2, 6, 0, 32767, -1};
      logic [31:0] q; logic [15:0] r; logic dz, ova, ira; int lat, t;
      for (int i = 0; i < 7; i++) begin
         do_op(16'(ta[i]), 16'(tb[i]), q, r, dz, lat, ova, ira, t);
         n_checks++;
         if (q !== 32'(tq[i]) || r !== 16'(tr[i]) || dz !== 1'b0) begin
            n_fail++;
            $display("FAIL signs[%0d] %0d/%0d: got q=%h r=%h dz=%b exp q=%h r=%h dz=0",
                     i, ta[i], tb[i], q, r, dz, 32'(tq[i]), 16'(tr[i]));
         end
      end
   endtask

   task automatic test_extremes();
      logic [31:0] q; logic [15:0] r; logic dz, ova, ira; int lat, t;
      do_op(16'h8000, 16'hFFFF, q, r, dz, lat, ova, ira, t);
      n_checks++;
      if (q !== 32'h0000_8000 || r !== 16'h0) begin
         n_fail++; $display("FAIL min_div_m1: got q=%h r=%h exp 00008000 0000", q, r);
      end
      do_op(16'h8000, 16'h0001, q, r, dz, lat, ova, ira, t);
      n_checks++;
      if (q !== 32'hFFFF_8000 || r !== 16'h0) begin
         n_fail++; $display("FAIL min_div_1: got q=%h r=%h exp ffff8000 0000", q, r);
      end
   endtask

   task automatic test_div_zero();
      logic [31:0] q; logic [15:0] r; logic dz, ova, ira; int lat, t;
      do_op(16'd5, 16'd0, q, r, dz, lat, ova, ira, t);
      n_checks++;
      if (dz !== 1'b1 || q !== 32'h0 || r !== 16'h0 || lat !== 17) begin
         n_fail++; $display("FAIL div_zero: got dz=%b q=%h r=%h lat=%0d exp 1 0 0 17", dz, q, r, lat);
      end
      do_op(16'd9, 16'd3, q, r, dz, lat, ova, ira, t);
      n_checks++;
      if (dz !== 1'b0 || q !== 32'd3 || r !== 16'd0) begin
         n_fail++; $display("FAIL after_zero: got dz=%b q=%0d r=%0d exp 0 3 0", dz, q, r);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] q0; logic [15:0] r0; int n; int bad;
      bus.out_ready = 1'b0;
      bus.a = 16'd100; bus.b = 16'd7; bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 100) begin step(); n++; end
      q0 = bus.q; r0 = bus.r;
      n_checks++;
      if (q0 !== 32'd14 || r0 !== 16'd2) begin
         n_fail++; $display("FAIL bp_result: got q=%0d r=%0d exp 14 2", q0, r0);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = i[0];
         bus.a = 16'($urandom); bus.b = 16'($urandom);
         step();
         if (bus.out_valid !== 1'b1 || bus.q !== q0 || bus.r !== r0 || bus.in_ready !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles exp 0", bad); end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      step();
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_release: got out_valid=%b in_ready=%b exp 0 1", bus.out_valid, bus.in_ready);
      end
      step();
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_no_queue: got in_ready=%b exp 1", bus.in_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] q; logic [15:0] r; logic dz, ova, ira; int lat, t1, t2;
      do_op(16'd1234, 16'd10, q, r, dz, lat, ova, ira, t1);
      do_op(16'hF000, 16'd300, q, r, dz, lat, ova, ira, t2);
      n_checks++;
      if (t2 - t1 !== 19) begin n_fail++; $display("FAIL b2b_interval: got %0d exp 19", t2 - t1); end
      n_checks++;
      if (q !== 32'(-4096 / 300) || r !== 16'(-4096 % 300)) begin
         n_fail++; $display("FAIL b2b_result: got q=%h r=%h", q, r);
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] q; logic [15:0] r; logic dz, ova, ira; int lat, t; logic seen;
      bus.a = 16'd1000; bus.b = 16'd3; bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      repeat (8) step();
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.q !== 32'h0 || bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL abort_reset: got out_valid=%b q=%h in_ready=%b exp 0 0 1",
                            bus.out_valid, bus.q, bus.in_ready);
      end
      step(); step();
      rst = 1'b0;
      seen = 1'b0;
      repeat (25) begin step(); if (bus.out_valid !== 1'b0) seen = 1'b1; end
      n_checks++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_stale: got stale out_valid exp none"); end
      do_op(16'd1000, 16'd3, q, r, dz, lat, ova, ira, t);
      n_checks++;
      if (q !== 32'd333 || r !== 16'd1 || dz !== 1'b0 || lat !== 17) begin
         n_fail++; $display("FAIL abort_redo: got q=%0d r=%0d dz=%b lat=%0d exp 333 1 0 17", q, r, dz, lat);
      end
   endtask

   task automatic test_random();
      logic [31:0] q, eq; logic [15:0] r, er, a, b; logic dz, edz, ova, ira; int lat, t;
      for (int i = 0; i < 40; i++) begin
         a = 16'($urandom);
         case ($urandom_range(0, 7))
            0: b = 16'h0000;
            1: b = 16'hFFFF;
            2: b = 16'h8000;
            3: b = 16'($urandom_range(1, 15));
            default: b = 16'($urandom);
         endcase
         if ($urandom_range(0, 9) == 0) a = 16'h8000;
         model(a, b, eq, er, edz);
         do_op(a, b, q, r, dz, lat, ova, ira, t);
         n_checks++;
         if (q !== eq || r !== er || dz !== edz || lat !== 17) begin
            n_fail++;
            $display("FAIL random[%0d] %h/%h: got q=%h r=%h dz=%b lat=%0d exp q=%h r=%h dz=%b lat=17",
                     i, a, b, q, r, dz, lat, eq, er, edz);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_extremes();
      test_div_zero();
      test_backpressure();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
